mem_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the fetch-side request port (inst) and the execute-side load/store port (data).
- Handshakes on both sides: req/addr_ok for the address phase, data_ok/rdata for the response phase. Responses return strictly in issue order.
- Tracks outstanding transactions in an in-order tag FIFO so each response goes back to the port that issued it.
- Supports fetch cancellation (branch/exception flush): inst responses that are cancelled are consumed internally and never forwarded.

---
 rtl/mem_req_arbiter_pkg.sv | 17 +
 rtl/mem_req_arbiter_fifo.sv | 65 ++++++
 rtl/mem_req_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
// Source encodings, access sizes and the in-order response tag.
package mem_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic src;
    logic discard;
  } tag_t;

endpackage

// File: rtl/mem_req_arbiter_fifo.sv
// In-order tag FIFO recording which port owns each outstanding response.
// A broadcast input marks every inst entry as discarded on a fetch flush.
module arb_tag_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  input  logic clear_discard_inst,
  output logic full,
  output logic empty,
  output tag_t head
);

  localparam int AW = $clog2(DEPTH);

  tag_t           mem_q [DEPTH];
  tag_t           mem_d [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clear_discard_inst && mem_q[i].src == SRC_INST)
        mem_d[i].discard = 1'b1;
    end
    // a freshly pushed tag already carries its own discard bit
    if (do_push)
      mem_d[wptr_q] = push_tag;
    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between fetch and load/store requesters.
// Responses return in issue order and are routed back by FIFO tag.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          gnt_inst, gnt_data;
  logic          fire, pop;
  logic          fifo_full, fifo_empty;
  logic          head_discard;
  tag_t          push_tag, head;

  assign gnt_inst = inst_req & (~data_req | (starve_cnt_q == STARVE_MAX));
  assign gnt_data = data_req & ~gnt_inst;

  assign fire = bus_req & bus_addr_ok;
  assign pop  = ~reset & bus_data_ok & ~fifo_empty;

  assign push_tag.src     = gnt_inst ? SRC_INST : SRC_DATA;
  assign push_tag.discard = gnt_inst & inst_cancel;

  // a flush landing on the pop cycle still suppresses that response
  assign head_discard = head.discard | inst_cancel;

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk                (clk),
    .reset              (reset),
    .push               (fire),
    .push_tag           (push_tag),
    .pop                (pop),
    .clear_discard_inst (inst_cancel),
    .full               (fifo_full),
    .empty              (fifo_empty),
    .head               (head)
  );

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!inst_req)
      starve_cnt_d = '0;
    else if (fire && gnt_inst)
      starve_cnt_d = '0;
    else if (fire && gnt_data && starve_cnt_q != STARVE_MAX)
      starve_cnt_d = starve_cnt_q + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt_q <= '0;
    else
      starve_cnt_q <= starve_cnt_d;
  end

  always_comb begin
    bus_req   = ~reset & (inst_req | data_req) & ~fifo_full;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_wstrb = 4'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    if (!reset) begin
      unique case (1'b1)
        gnt_inst: begin
          bus_size = SZ_W;
          bus_addr = inst_addr;
        end
        gnt_data: begin
          bus_wr    = data_wr;
          bus_size  = data_size;
          bus_wstrb = data_wstrb;
          bus_addr  = data_addr;
          bus_wdata = data_wdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    inst_addr_ok = fire & gnt_inst;
    data_addr_ok = fire & gnt_data;
    inst_data_ok = pop & (head.src == SRC_INST) & ~head_discard;
    data_data_ok = pop & (head.src == SRC_DATA);
    inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    data_rdata   = data_data_ok ? bus_rdata : 32'd0;
  end

  a_no_orphan_rsp: assert property (
    @(posedge clk) disable iff (reset) !(bus_data_ok && fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter against a queue-based reference.
// Stimulus pushes per-cycle expectations; a monitor compares mid-cycle.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 0, inst_cancel = 0;
  logic [31:0] inst_addr = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [3:0]  data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 0, bus_data_ok = 0;
  logic [31:0] bus_rdata = 0;

  mem_req_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit        breq, iaok, daok;
    bit [31:0] addr, wdata;
    bit        wr;
    bit [1:0]  size;
    bit [3:0]  wstrb;
    bit        iok, dok;
    bit [31:0] ird, drd;
  } exp_t;

  typedef struct {
    bit        is_inst;
    bit        dead;
    bit [31:0] rdata;
  } ent_t;

  exp_t expq[$];
  ent_t outst[$];
  int   wins = 0;
  int   seq  = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: one expectation record per cycle, checked mid-cycle
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.rst) begin
          chk("rst_ctl", 32'({bus_req, inst_addr_ok, data_addr_ok,
              inst_data_ok, data_data_ok, bus_wr, bus_size, bus_wstrb}), 0);
          chk("rst_dat", bus_addr | bus_wdata | inst_rdata | data_rdata, 0);
        end else begin
          chk("bus_req", 32'(bus_req), 32'(e.breq));
          chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e.iaok));
          chk("data_addr_ok", 32'(data_addr_ok), 32'(e.daok));
          if (e.breq) begin
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_ctl", 32'({bus_wr, bus_size, bus_wstrb}),
                32'({e.wr, e.size, e.wstrb}));
            chk("bus_wdata", bus_wdata, e.wdata);
          end
          chk("inst_data_ok", 32'(inst_data_ok), 32'(e.iok));
          chk("inst_rdata", inst_rdata, e.ird);
          chk("data_data_ok", 32'(data_data_ok), 32'(e.dok));
          chk("data_rdata", data_rdata, e.drd);
        end
      end
    end
  end

  task automatic step(input bit ir, input bit [31:0] ia, input bit ic,
                      input bit dr, input bit dw, input bit [1:0] ds,
                      input bit [3:0] dst, input bit [31:0] da,
                      input bit [31:0] dwd, input bit baok, input bit bdok);
    exp_t e;
    ent_t h, n;
    bit   gi, gd, fire, dok;
    @(posedge clk);
    #1;
    e = '{default: '0};
    dok = bdok && (outst.size() > 0);
    reset = 0;
    inst_req = ir; inst_addr = ia; inst_cancel = ic;
    data_req = dr; data_wr = dw; data_size = ds; data_wstrb = dst;
    data_addr = da; data_wdata = dwd;
    bus_addr_ok = baok; bus_data_ok = dok;
    bus_rdata = dok ? outst[0].rdata : $urandom;
    e.breq = (ir || dr) && (outst.size() < 4);
    gi = ir && (!dr || wins == 4);
    gd = dr && !gi;
    fire = e.breq && baok;
    e.iaok = fire && gi;
    e.daok = fire && gd;
    if (gi) begin
      e.addr = ia; e.size = 2'd2;
    end else if (gd) begin
      e.addr = da; e.wr = dw; e.size = ds; e.wstrb = dst; e.wdata = dwd;
    end
    if (dok) begin
      h = outst.pop_front();
      if (!h.is_inst) begin
        e.dok = 1; e.drd = h.rdata;
      end else if (!h.dead && !ic) begin
        e.iok = 1; e.ird = h.rdata;
      end
    end
    if (ic)
      foreach (outst[i]) if (outst[i].is_inst) outst[i].dead = 1;
    if (fire) begin
      seq++;
      n.is_inst = gi;
      n.dead = gi && ic;
      n.rdata = (seq <= 2) ? (32'hAAAA0000 | 32'(seq)) : $urandom;
      outst.push_back(n);
    end
    if (!ir || (fire && gi)) wins = 0;
    else if (fire && gd && wins < 4) wins++;
    expq.push_back(e);
  endtask

  task automatic rst_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1;
      inst_req = 1; inst_cancel = 1; data_req = 1; data_wr = 1;
      data_wstrb = 4'hF; data_addr = $urandom; data_wdata = $urandom;
      bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = $urandom;
      e = '{default: '0};
      e.rst = 1;
      expq.push_back(e);
      outst.delete();
      wins = 0;
    end
  endtask

  task automatic idle(input bit baok, input bit bdok);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, baok, bdok);
  endtask

  task automatic fetch(input bit [31:0] a, input bit ic, input bit bdok);
    step(1, a, ic, 0, 0, 0, 0, 0, 0, 1, bdok);
  endtask

  initial begin
    rst_cycles(2);
    // back-to-back fetches with immediate responses
    fetch(32'h1c000000, 0, 0);
    fetch(32'h1c000004, 0, 1);
    idle(0, 1);
    // contention: data wins four times, then inst is forced
    for (int i = 0; i < 7; i++)
      step(1, 32'h1c000008, 0, 1, 0, 2'd2, 4'hF, 32'h80000010, 0, 1, 1);
    for (int i = 0; i < 4; i++) idle(0, 1);
    // fill the FIFO, pop once while full, accept one cycle later
    for (int i = 0; i < 6; i++)
      step(1, 32'h1c000100 + 4 * i, 0, 1, 1, 2'd0, 4'b0001,
           32'h80000020, 32'h12345678, 1, 0);
    step(0, 0, 0, 1, 0, 2'd1, 4'b0011, 32'h80000040, 0, 1, 1);
    step(0, 0, 0, 1, 0, 2'd1, 4'b0011, 32'h80000040, 0, 1, 0);
    for (int i = 0; i < 5; i++) idle(0, 1);
    // flush two outstanding fetches, then a store
    fetch(32'h1c000200, 0, 0);
    fetch(32'h1c000204, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 2'd1, 4'b0011, 32'h80000030, 32'hCAFE, 1, 0);
    for (int i = 0; i < 4; i++) idle(0, 1);
    // cancel coinciding with a new fetch and an inst response pop
    fetch(32'h1c000300, 0, 0);
    fetch(32'h1c000304, 1, 1);
    fetch(32'h1c000308, 0, 1);
    idle(0, 1);
    idle(0, 1);
    // reset with three outstanding, then a normal fetch
    fetch(32'h1c000400, 0, 0);
    fetch(32'h1c000404, 0, 0);
    step(0, 0, 0, 1, 0, 2'd2, 4'hF, 32'h80000050, 0, 1, 0);
    rst_cycles(2);
    fetch(32'h1c000500, 0, 0);
    idle(0, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
           2'($urandom_range(0, 2)), 4'($urandom), $urandom, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
      if ($urandom_range(0, 499) == 0) rst_cycles(1);
    end
    for (int i = 0; i < 6; i++) idle(0, 1);
    @(posedge clk);
    #1;
    inst_req = 0; data_req = 0; inst_cancel = 0;
    bus_addr_ok = 0; bus_data_ok = 0;
    @(negedge clk);
    #1;
    done = 1;
    chk("scoreboard_drained", 32'(expq.size()), 0);
    chk("model_outstanding", 32'(outst.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
